// File: rtl/apb_cmd_initiator.sv
// APB4 requester: queues read/write commands, runs one APB transfer per
// command and hands back one response per command in order.
module apb_cmd_initiator #(
    parameter int BW         = 64,
    parameter int DW         = 16,
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16,
    localparam int SW        = BW / DW
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [BW-1:0]     cmd_wdata_i,
    input  logic [SW-1:0]     cmd_strb_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [BW-1:0]     rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              rsp_timeout_o,
    output logic              psel_o,
    output logic              penable_o,
    output logic              pwrite_o,
    output logic [SW-1:0]     pstrb_o,
    output logic [BW-1:0]     pwdata_o,
    output logic [ADDR_W-1:0] paddr_o,
    input  logic [BW-1:0]     prdata_i,
    input  logic              pready_i,
    input  logic              pslverr_i,
    output logic              busy_o
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic              fifo_write [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_addr  [FIFO_DEPTH];
    logic [BW-1:0]     fifo_wdata [FIFO_DEPTH];
    logic [SW-1:0]     fifo_strb  [FIFO_DEPTH];

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          fifo_full, fifo_empty, push, pop;

    logic              head_write;
    logic [ADDR_W-1:0] head_addr;
    logic [BW-1:0]     head_wdata;
    logic [SW-1:0]     head_strb;

    logic [TW-1:0] wait_cnt_q;
    logic          timeout_hit;
    logic          rsp_slot_free;
    logic          rsp_load, rsp_abort;
    logic          active;

    logic          rsp_valid_q, rsp_err_q, rsp_timeout_q;
    logic [BW-1:0] rsp_rdata_q;

    assign fifo_full   = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty  = (count_q == '0);
    // Held low during reset so nothing is accepted until the block is live.
    assign cmd_ready_o = rst_ni & ~fifo_full;
    assign push        = cmd_valid_i & cmd_ready_o;

    assign head_write = fifo_write[rd_ptr_q];
    assign head_addr  = fifo_addr[rd_ptr_q];
    assign head_wdata = fifo_wdata[rd_ptr_q];
    assign head_strb  = fifo_strb[rd_ptr_q];

    assign rsp_slot_free = ~rsp_valid_q | rsp_ready_i;
    assign timeout_hit   = (TIMEOUT > 0) && (wait_cnt_q == TW'(TIMEOUT - 1));

    // Command storage; contents are only meaningful between push and pop.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_write[wr_ptr_q] <= cmd_write_i;
            fifo_addr[wr_ptr_q]  <= cmd_addr_i;
            fifo_wdata[wr_ptr_q] <= cmd_wdata_i;
            fifo_strb[wr_ptr_q]  <= cmd_strb_i;
        end
    end

    // Queue pointers and occupancy; pointers wrap because depth is a power of 2.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Transfer state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state plus completion/abort strobes for the queue and response.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        rsp_load  = 1'b0;
        rsp_abort = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty && rsp_slot_free) state_d = SETUP;
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (pready_i) begin
                    pop      = 1'b1;
                    rsp_load = 1'b1;
                    state_d  = IDLE;
                end else if (timeout_hit) begin
                    pop       = 1'b1;
                    rsp_abort = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Counts wait states in ACCESS; restarts for every new transfer in SETUP.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt_q <= '0;
        end else if (state_q == SETUP) begin
            wait_cnt_q <= '0;
        end else if (state_q == ACCESS && !pready_i) begin
            wait_cnt_q <= wait_cnt_q + TW'(1);
        end
    end

    // Single response slot: loaded on completion or abort, cleared on handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else if (rsp_load) begin
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= head_write ? '0 : prdata_i;
            rsp_err_q     <= pslverr_i;
            rsp_timeout_q <= 1'b0;
        end else if (rsp_abort) begin
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
        end else if (rsp_valid_q && rsp_ready_i) begin
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end
    end

    // Bus outputs decode straight from the state so an async reset drops them at once.
    assign active    = (state_q != IDLE);
    assign psel_o    = active;
    assign penable_o = (state_q == ACCESS);
    assign pwrite_o  = active & head_write;
    assign paddr_o   = active ? head_addr : '0;
    assign pwdata_o  = (active && head_write) ? head_wdata : '0;
    assign pstrb_o   = (active && head_write) ? head_strb : '0;

    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_timeout_q;

    assign busy_o = !fifo_empty || active || rsp_valid_q;

endmodule

// File: tb/tb_apb_cmd_initiator.sv
// Self-checking bench for apb_cmd_initiator: directed vector table, multi-cycle
// corner sequences and a randomized run scored against a memory-level model.
module tb_apb_cmd_initiator;

    logic        clk;
    logic        rstN;
    logic        cmdValid;
    logic        cmdReady;
    logic        cmdWrite;
    logic [31:0] cmdAddr;
    logic [63:0] cmdWdata;
    logic [3:0]  cmdStrb;
    logic        rspValid;
    logic        rspReady;
    logic [63:0] rspRdata;
    logic        rspErr;
    logic        rspTimeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [3:0]  pstrb;
    logic [63:0] pwdata;
    logic [31:0] paddr;
    logic [63:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        busy;

    // Directed responder values vs. randomized responder values.
    logic        randMode;
    logic        dirPready, dirSlverr;
    logic [63:0] dirPrdata;
    logic        rndPready, rndSlverr;
    logic [63:0] rndPrdata;

    assign pready  = randMode ? rndPready : dirPready;
    assign pslverr = randMode ? rndSlverr : dirSlverr;
    assign prdata  = randMode ? rndPrdata : dirPrdata;

    int passCount  = 0;
    int checkCount = 0;

    apb_cmd_initiator #(
        .BW(64), .DW(16), .ADDR_W(32), .FIFO_DEPTH(4), .TIMEOUT(16)
    ) dut (
        .clk_i(clk), .rst_ni(rstN),
        .cmd_valid_i(cmdValid), .cmd_ready_o(cmdReady), .cmd_write_i(cmdWrite),
        .cmd_addr_i(cmdAddr), .cmd_wdata_i(cmdWdata), .cmd_strb_i(cmdStrb),
        .rsp_valid_o(rspValid), .rsp_ready_i(rspReady), .rsp_rdata_o(rspRdata),
        .rsp_err_o(rspErr), .rsp_timeout_o(rspTimeout),
        .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .pstrb_o(pstrb),
        .pwdata_o(pwdata), .paddr_o(paddr), .prdata_i(prdata), .pready_i(pready),
        .pslverr_i(pslverr), .busy_o(busy)
    );

    // Free-running clock, posedges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something upstream never terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [3:0]  strb;
        int          waits;
        logic [63:0] prdata;
        logic        slverr;
        logic        noise;
        logic [3:0]  expStrb;
        logic [63:0] expWdata;
        logic [63:0] expRdata;
        logic        expErr;
    } vec_t;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t expQ[$];
    logic [63:0] modelMem [16];

    function automatic logic [63:0] memInit(input int i);
        return {16'hA5A5, 16'(i), 32'h600D_0000};
    endfunction

    function automatic logic [63:0] mergeStrb(input logic [63:0] old, input logic [63:0] wd,
                                              input logic [3:0] st);
        logic [63:0] r;
        r = old;
        for (int l = 0; l < 4; l++) if (st[l]) r[l*16 +: 16] = wd[l*16 +: 16];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic valid, input logic write, input logic [31:0] addr,
                                 input logic [63:0] wdata, input logic [3:0] strb);
        cmdValid = valid;
        cmdWrite = write;
        cmdAddr  = addr;
        cmdWdata = wdata;
        cmdStrb  = strb;
    endtask

    // Randomized responder: 0-3 wait states, error on address block 0xF, memory-backed.
    initial begin
        logic [63:0] respMem [16];
        int rndWait;
        int idx;
        for (int i = 0; i < 16; i++) respMem[i] = memInit(i);
        rndWait   = 0;
        rndPready = 1'b0;
        rndSlverr = 1'b0;
        rndPrdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (randMode) begin
                if (psel && !penable) begin
                    rndWait   = $urandom_range(0, 3);
                    rndPready = 1'b0;
                    rndSlverr = 1'b0;
                end else if (psel && penable) begin
                    if (rndWait == 0) begin
                        idx       = int'(paddr[7:4]);
                        rndPready = 1'b1;
                        rndPrdata = respMem[idx];
                        rndSlverr = (idx == 15);
                        if (pwrite && idx != 15) respMem[idx] = mergeStrb(respMem[idx], pwdata, pstrb);
                    end else begin
                        rndWait--;
                        rndPready = 1'b0;
                        rndSlverr = 1'($urandom_range(0, 1));
                        rndPrdata = {$urandom, $urandom};
                    end
                end else begin
                    rndPready = 1'b0;
                    rndSlverr = 1'b0;
                end
            end
        end
    end

    // One full transfer described by a table row, with the responder driven by hand.
    task automatic runVector(input vec_t v, input string nm);
        int enCycles;
        int waitsLeft;
        int guard;
        logic stable;
        applyStimulus(1'b1, v.write, v.addr, v.wdata, v.strb);
        step();
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        checkOutput({nm, ".idle_after_push"}, psel, 0);
        step();
        checkOutput({nm, ".setup_psel"}, {penable, psel}, 2'b01);
        checkOutput({nm, ".setup_paddr"}, paddr, v.addr);
        checkOutput({nm, ".setup_pwrite"}, pwrite, v.write);
        checkOutput({nm, ".setup_pstrb"}, pstrb, v.expStrb);
        checkOutput({nm, ".setup_pwdata"}, pwdata, v.expWdata);
        step();
        enCycles  = 0;
        waitsLeft = v.waits;
        stable    = 1'b1;
        guard     = 0;
        while (psel && guard < 40) begin
            if (penable) enCycles++;
            if (paddr !== v.addr || pstrb !== v.expStrb || pwdata !== v.expWdata) stable = 1'b0;
            if (waitsLeft == 0) begin
                dirPready = 1'b1;
                dirPrdata = v.prdata;
                dirSlverr = v.slverr;
            end else begin
                dirPready = 1'b0;
                dirPrdata = ~v.prdata;
                dirSlverr = v.noise;
                waitsLeft--;
            end
            guard++;
            step();
        end
        dirPready = 1'b0;
        dirSlverr = 1'b0;
        checkOutput({nm, ".penable_cycles"}, 64'(enCycles), 64'(v.waits + 1));
        checkOutput({nm, ".bus_stable"}, stable, 1);
        checkOutput({nm, ".rsp_valid"}, rspValid, 1);
        checkOutput({nm, ".rsp_rdata"}, rspRdata, v.expRdata);
        checkOutput({nm, ".rsp_err"}, rspErr, v.expErr);
        checkOutput({nm, ".rsp_timeout"}, rspTimeout, 0);
        rspReady = 1'b1;
        step();
        rspReady = 1'b0;
        checkOutput({nm, ".rsp_cleared"}, rspValid, 0);
        checkOutput({nm, ".busy_done"}, busy, 0);
    endtask

    // Score a response that handshakes at the coming edge against the model queue.
    task automatic scoreRsp();
        exp_t e;
        if (rspValid && rspReady) begin
            if (expQ.size() == 0) begin
                checkOutput("rnd.unexpected_rsp", 1, 0);
            end else begin
                e = expQ.pop_front();
                checkOutput("rnd.rdata", rspRdata, e.rdata);
                checkOutput("rnd.err_timeout", {rspErr, rspTimeout}, {e.err, 1'b0});
            end
        end
    endtask

    // Model an accepted random command: memory update for writes, expected response.
    task automatic modelPush();
        int   idx;
        exp_t e;
        idx   = int'(cmdAddr[7:4]);
        e.err = (idx == 15);
        if (cmdWrite) begin
            e.rdata = '0;
            if (idx != 15) modelMem[idx] = mergeStrb(modelMem[idx], cmdWdata, cmdStrb);
        end else begin
            e.rdata = modelMem[idx];
        end
        expQ.push_back(e);
    endtask

    initial begin
        vec_t vecs[5];
        logic [31:0] qAddr [5];
        int accepted, got, guard, acc;
        logic sawSetup;

        vecs[0] = '{1'b1, 32'h10, 64'h0004_0003_0002_0001, 4'hF, 0, 64'hFFFF_FFFF_FFFF_FFFF,
                    1'b0, 1'b0, 4'hF, 64'h0004_0003_0002_0001, 64'h0, 1'b0};
        vecs[1] = '{1'b0, 32'h20, 64'h5555_5555_5555_5555, 4'hF, 3, 64'hDEAD_BEEF_0123_4567,
                    1'b0, 1'b0, 4'h0, 64'h0, 64'hDEAD_BEEF_0123_4567, 1'b0};
        vecs[2] = '{1'b0, 32'h30, 64'h0, 4'h0, 2, 64'h0123_4567_89AB_CDEF,
                    1'b1, 1'b1, 4'h0, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b1};
        vecs[3] = '{1'b0, 32'h38, 64'h0, 4'h0, 3, 64'h0F0F_0F0F_0F0F_0F0F,
                    1'b0, 1'b1, 4'h0, 64'h0, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0};
        vecs[4] = '{1'b1, 32'h44, 64'h1111_2222_3333_4444, 4'b0101, 1, 64'hAAAA_AAAA_AAAA_AAAA,
                    1'b1, 1'b0, 4'b0101, 64'h1111_2222_3333_4444, 64'h0, 1'b1};
        qAddr = '{32'h100, 32'h108, 32'h110, 32'h118, 32'h120};

        randMode  = 1'b0;
        dirPready = 1'b0;
        dirSlverr = 1'b0;
        dirPrdata = '0;
        rspReady  = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 16; i++) modelMem[i] = memInit(i);

        // Reset state.
        rstN = 1'b0;
        step();
        step();
        checkOutput("reset.cmd_ready", cmdReady, 0);
        checkOutput("reset.psel_penable", {psel, penable}, 0);
        checkOutput("reset.rsp", {rspValid, rspErr, rspTimeout}, 0);
        checkOutput("reset.rdata", rspRdata, 0);
        checkOutput("reset.bus", {pwrite, pstrb, paddr}, 0);
        checkOutput("reset.pwdata", pwdata, 0);
        checkOutput("reset.busy", busy, 0);
        rstN = 1'b1;
        step();
        checkOutput("reset.cmd_ready_released", cmdReady, 1);

        // Table-driven single transfers.
        for (int i = 0; i < 5; i++) runVector(vecs[i], $sformatf("vec%0d", i));

        // Timeout: pready stuck low with pslverr noise.
        applyStimulus(1'b1, 1'b0, 32'h50, '0, '0);
        step();
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        step();
        checkOutput("timeout.setup", {penable, psel}, 2'b01);
        step();
        acc   = 0;
        guard = 0;
        while (psel && guard < 40) begin
            if (penable) acc++;
            dirPready = 1'b0;
            dirSlverr = guard[0];
            guard++;
            step();
        end
        dirSlverr = 1'b0;
        checkOutput("timeout.access_cycles", 64'(acc), 16);
        checkOutput("timeout.psel_dropped", psel, 0);
        checkOutput("timeout.rsp_valid", rspValid, 1);
        checkOutput("timeout.flags", {rspErr, rspTimeout}, 2'b11);
        checkOutput("timeout.rdata", rspRdata, 0);
        rspReady = 1'b1;
        step();
        rspReady = 1'b0;
        checkOutput("timeout.busy_done", busy, 0);

        // Queue full plus response backpressure.
        accepted = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, qAddr[i], 64'h0, 4'h0);
            if (cmdReady) accepted++;
            if (i < 4) step();
        end
        checkOutput("full.cmd_ready", cmdReady, 0);
        checkOutput("full.accepted", 64'(accepted), 4);
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        dirPready = 1'b1;
        dirPrdata = {32'hC0DE_0000, paddr};
        step();
        dirPready = 1'b0;
        checkOutput("full.first_rsp_valid", rspValid, 1);
        sawSetup = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (psel) sawSetup = 1'b1;
            step();
        end
        checkOutput("full.no_second_setup", sawSetup, 0);
        checkOutput("full.ready_after_pop", cmdReady, 1);
        checkOutput("full.busy_held", busy, 1);
        got   = 0;
        guard = 0;
        rspReady = 1'b1;
        while ((got < 4 || busy) && guard < 80) begin
            dirPready = psel && penable;
            dirPrdata = {32'hC0DE_0000, paddr};
            if (rspValid) begin
                if (got < 4) checkOutput($sformatf("full.order%0d", got), rspRdata,
                                         {32'hC0DE_0000, qAddr[got]});
                got++;
            end
            guard++;
            step();
        end
        rspReady  = 1'b0;
        dirPready = 1'b0;
        checkOutput("full.rsp_count", 64'(got), 4);
        checkOutput("full.busy_done", busy, 0);

        // Reset during ACCESS with two more commands queued.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 32'h200 + 32'(i * 8), 64'h77, 4'hF);
            step();
        end
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        checkOutput("rst_mid.in_access", {penable, psel}, 2'b11);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("rst_mid.psel_immediate", {psel, penable}, 0);
        checkOutput("rst_mid.busy_in_reset", busy, 0);
        step();
        step();
        rstN = 1'b1;
        sawSetup = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (psel) sawSetup = 1'b1;
            step();
        end
        checkOutput("rst_mid.fifo_flushed", sawSetup, 0);
        checkOutput("rst_mid.rsp_valid", rspValid, 0);
        checkOutput("rst_mid.busy", busy, 0);
        checkOutput("rst_mid.cmd_ready", cmdReady, 1);

        // Randomized traffic against the memory model.
        randMode = 1'b1;
        for (int c = 0; c < 400; c++) begin
            applyStimulus($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), $urandom,
                          {$urandom, $urandom}, 4'($urandom_range(0, 15)));
            rspReady = ($urandom_range(0, 3) != 0);
            if (cmdValid && cmdReady) modelPush();
            scoreRsp();
            step();
        end
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        rspReady = 1'b1;
        guard    = 0;
        while ((expQ.size() > 0 || busy) && guard < 300) begin
            scoreRsp();
            guard++;
            step();
        end
        checkOutput("rnd.queue_drained", 64'(expQ.size()), 0);
        checkOutput("rnd.busy_done", busy, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/apb_cmd_initiator.md
Name: apb_cmd_initiator

Overview:
- APB4 requester (initiator) that drives the psel/penable/pwrite/pstrb/pwdata/paddr side of the bus, and samples prdata/pready/pslverr from a responder such as the matrix-multiply accelerator.
- Accepts read/write commands through a valid/ready queue and runs one APB transfer per command.
- Returns one response per command (read data, slave error, timeout).
- Synthesizable replacement for hand-driven stimulus, used by the host-side controller.

Parameters:
- BW, 64, APB data width (pwdata/prdata).
- DW, 16, element width; strobe granularity.
- ADDR_W, 32, address width.
- FIFO_DEPTH, 4, command queue entries (power of 2, >=2).
- TIMEOUT, 16, max consecutive ACCESS cycles with pready low before abort; 0 disables the timeout.
- Derived: SW = BW/DW, the strobe width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  async active-low reset.
- cmd_valid_i  in  1  command offered.
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
- cmd_write_i  in  1  1=write, 0=read.
- cmd_addr_i  in  ADDR_W  transfer address.
- cmd_wdata_i  in  BW  write data.
- cmd_strb_i  in  SW  write strobes, one per DW lane.
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  response consumed.
- rsp_rdata_o  out  BW  read data; 0 for writes and aborted transfers.
- rsp_err_o  out  1  pslverr or timeout.
- rsp_timeout_o  out  1  transfer aborted by timeout.
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- pwrite_o  out  1  APB direction.
- pstrb_o  out  SW  APB strobes.
- pwdata_o  out  BW  APB write data.
- paddr_o  out  ADDR_W  APB address.
- prdata_i  in  BW  APB read data.
- pready_i  in  1  APB ready.
- pslverr_i  in  1  APB slave error.
- busy_o  out  1  work pending.

Behaviour:
- Clock and reset: single clock clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values: all outputs 0, except cmd_ready_o, which goes to 1 once reset is released. The FIFO is empty and the FSM is in IDLE.
- Reset asserted mid-transfer: psel_o and penable_o drop immediately without waiting for a clock edge. Queued commands and any pending response are discarded.
- Command FIFO:
  - cmd_ready_o = !full, based on current occupancy. A push while full is refused even if a pop happens in the same cycle.
  - Push happens on cmd_valid_i && cmd_ready_o.
  - Pop happens at transfer completion or abort.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - Go to SETUP when the FIFO is non-empty and the response slot is free, i.e. rsp_valid_o==0, or rsp_valid_o && rsp_ready_i in the same cycle.
  - psel_o=0, penable_o=0.
- SETUP, exactly one cycle:
  - psel_o=1, penable_o=0.
  - paddr_o, pwrite_o, pwdata_o and pstrb_o come from the FIFO head.
  - For reads, pwdata_o=0 and pstrb_o=0.
  - Always go to ACCESS next.
- ACCESS:
  - psel_o=1, penable_o=1. All address/control/data outputs hold their SETUP values for the whole transfer.
  - On pready_i=1:
    - Load the response register: rsp_valid_o=1, rsp_rdata_o = prdata_i for reads or 0 for writes, rsp_err_o=pslverr_i, rsp_timeout_o=0.
    - Pop the FIFO and go to IDLE.
    - pslverr_i is ignored while pready_i=0.
  - Wait-state counter: counts ACCESS cycles with pready_i=0 and clears on entry to SETUP.
  - If TIMEOUT>0 and the counter reaches TIMEOUT with pready_i still 0:
    - Abort: load the response with rdata=0, err=1, timeout=1.
    - Pop the FIFO, go to IDLE, and deassert psel_o/penable_o on the next cycle.
- Back-to-back throughput: minimum 3 cycles per transfer (SETUP, ACCESS, IDLE) when pready_i=1 and rsp_ready_i=1.
- Response register: holds its value until rsp_valid_o && rsp_ready_i, then clears rsp_valid_o. Responses are returned in command order.
- Response backpressure: while a response is held, no new SETUP starts. The FIFO keeps accepting commands until it is full.
- Address: paddr_o is passed through unmodified; alignment is the requester's responsibility.
- busy_o = FIFO non-empty || state!=IDLE || rsp_valid_o.

Test Plan:
1. Write, no wait states: addr 0x10, wdata 0x0004_0003_0002_0001, strb 4'hF, pready_i=1.
   - Expected: psel_o rises at cycle t, penable_o at t+1. Response at t+2 with err=0, rdata=0.
2. Read with 3 wait states: addr 0x20, prdata_i=0xDEAD_BEEF_0123_4567.
   - Expected: penable_o high for 4 cycles. pstrb_o=0 and paddr_o stable throughout. rsp_rdata_o=0xDEAD_BEEF_0123_4567.
3. Slave error: read with pready_i=1 and pslverr_i=1.
   - Expected: rsp_err_o=1, rsp_timeout_o=0. pslverr_i pulses during wait states before pready_i must not set err.
4. Timeout: TIMEOUT=16 and pready_i held 0.
   - Expected: abort after 16 ACCESS cycles. Response err=1, timeout=1, rdata=0. psel_o=0 the next cycle.
5. Queue full plus response backpressure: push 5 commands with rsp_ready_i=0.
   - Expected: 4 accepted and cmd_ready_o=0. Exactly one transfer completes and no second SETUP starts.
   - Release rsp_ready_i: all 4 responses return in order, then busy_o=0.
6. Reset asserted in ACCESS with 2 commands queued.
   - Expected: psel_o=0 immediately. After release, rsp_valid_o=0, FIFO empty, busy_o=0.
